// File: rtl/de0nano_board_pkg.sv
// Shared constants and types for the DE0-Nano board blocks.
// Covers the ADC128S022 frame layout and the responder state type.
package de0nano_board_pkg;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_BITS  = 12;
  localparam int ADC_CHANNELS   = 8;
  localparam int ADC_ADDR_MSB   = 13;
  localparam int ADC_CH_BITS    = 3;
  localparam int ADC_CNT_BITS   = 5;

  typedef enum logic {
    IDLE,
    SHIFT
  } adc_state_t;

  // Outgoing frame: leading zeros, then the 12-bit sample of channel ch.
  function automatic logic [ADC_FRAME_BITS-1:0] adc_frame(
    input logic [ADC_CHANNELS*ADC_DATA_BITS-1:0] ch_data,
    input logic [ADC_CH_BITS-1:0]                ch
  );
    return {{(ADC_FRAME_BITS-ADC_DATA_BITS){1'b0}},
            ch_data[int'(ch)*ADC_DATA_BITS +: ADC_DATA_BITS]};
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin, followed by a registered
// edge detector producing single-cycle rise and fall strobes.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // NOTE: reset is synchronous, so it only takes effect on a clock edge;
  // sequential state always uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  // Level is taken one stage late so it lines up with the strobes.
  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/adc128s022_responder.sv
// ADC128S022 SPI responder emulator: oversamples SCLK/CS_N/DIN on CLOCK_50,
// captures the channel address and returns {4'b0, sample} per 16-bit frame.
module adc128s022_responder
  import de0nano_board_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                                  CLOCK_50,
  input  logic                                  rst_n,
  input  logic                                  spi_sclk,
  input  logic                                  spi_cs_n,
  input  logic                                  spi_din,
  output logic                                  spi_dout,
  output logic                                  dout_oe,
  input  logic [ADC_CHANNELS*ADC_DATA_BITS-1:0] ch_data,
  output logic [ADC_CH_BITS-1:0]                addr,
  output logic                                  addr_valid,
  output logic [15:0]                           frame_count,
  output logic                                  busy
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, din_lvl;
  logic sclk_level_unused, cs_level_unused, din_rise_unused, din_fall_unused;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(CLOCK_50), .rst_n(rst_n), .async_i(spi_sclk),
    .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(CLOCK_50), .rst_n(rst_n), .async_i(spi_cs_n),
    .level_o(cs_level_unused), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk(CLOCK_50), .rst_n(rst_n), .async_i(spi_din),
    .level_o(din_lvl), .rise_o(din_rise_unused), .fall_o(din_fall_unused)
  );

  adc_state_t                state_q, state_d;
  logic [ADC_FRAME_BITS-1:0] shift_q, shift_d;
  logic [ADC_FRAME_BITS-1:0] din_q, din_d;
  logic [ADC_CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [ADC_CH_BITS-1:0]    next_ch_q, next_ch_d;
  logic [ADC_CH_BITS-1:0]    addr_q, addr_d;
  logic                      valid_q, valid_d;
  logic [15:0]               fc_q, fc_d;
  logic                      dout_q, dout_d;

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      din_q     <= '0;
      cnt_q     <= '0;
      next_ch_q <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      fc_q      <= '0;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      din_q     <= din_d;
      cnt_q     <= cnt_d;
      next_ch_q <= next_ch_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      fc_q      <= fc_d;
      dout_q    <= dout_d;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    din_d     = din_q;
    cnt_d     = cnt_q;
    next_ch_d = next_ch_q;
    addr_d    = addr_q;
    valid_d   = 1'b0;
    fc_d      = fc_q;
    dout_d    = dout_q;

    unique case (state_q)
      IDLE: begin
        // Any sclk edge arriving with cs_fall is deliberately ignored here.
        if (cs_fall) begin
          shift_d = adc_frame(ch_data, next_ch_q);
          dout_d  = shift_d[ADC_FRAME_BITS-1];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          din_d = {din_q[ADC_FRAME_BITS-2:0], din_lvl};
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == ADC_CNT_BITS'(ADC_FRAME_BITS)) begin
            addr_d    = din_d[ADC_ADDR_MSB -: ADC_CH_BITS];
            next_ch_d = addr_d;
            valid_d   = 1'b1;
            fc_d      = fc_q + 16'd1;
            shift_d   = adc_frame(ch_data, addr_d);
            cnt_d     = '0;
          end
        end else if (sclk_fall) begin
          // With bit_cnt at 0 a fresh frame is loaded: present its MSB unshifted.
          if (cnt_q == '0) begin
            dout_d = shift_q[ADC_FRAME_BITS-1];
          end else begin
            shift_d = {shift_q[ADC_FRAME_BITS-2:0], 1'b0};
            dout_d  = shift_q[ADC_FRAME_BITS-2];
          end
        end
        // Completion above is already committed when cs_rise coincides.
        if (cs_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == SHIFT);
  assign dout_oe     = busy;
  assign spi_dout    = dout_q;
  assign addr        = addr_q;
  assign addr_valid  = valid_q;
  assign frame_count = fc_q;

endmodule
